// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID
// register. It freezes on data hazards, inserts bubbles while a branch is pending and redirects on resolve.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        IFstall,
    input  logic        IDstall,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] IDinstr,
    output logic [31:0] IDpc4,
    output logic        IDvalid,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
);

    // state  | meaning
    // S_RUN  | normal sequential fetch
    // S_WAIT | branch pending; PC held at fall-through, bubbles issued until resolve
    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic        load_fetch, load_bubble;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        load_fetch  = 1'b0;
        load_bubble = 1'b0;
        if (br_resolve) begin
            state_nxt = S_RUN;
            if (br_taken) begin
                pc_nxt      = br_target & 32'hFFFF_FFFC;
                load_bubble = !IDstall;
            end else begin
                pc_nxt     = pc_plus4;
                load_fetch = !IDstall;
            end
        end else if (IDstall) begin
            state_nxt = state;
        end else if (IFstall) begin
            load_bubble = 1'b1;
            state_nxt   = S_WAIT;
        end else if (state == S_WAIT) begin
            // resolve still outstanding even after IFstall drops
            load_bubble = 1'b1;
        end else begin
            pc_nxt     = pc_plus4;
            load_fetch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            IDinstr    <= NOP;
            IDpc4      <= 32'd0;
            IDvalid    <= 1'b0;
            fetch_cnt  <= 16'd0;
            bubble_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_fetch) begin
                IDinstr   <= imem_data;
                IDpc4     <= pc_plus4;
                IDvalid   <= 1'b1;
                fetch_cnt <= fetch_cnt + 16'd1;
            end else if (load_bubble) begin
                IDinstr <= NOP;
                IDpc4   <= 32'd0;
                IDvalid <= 1'b0;
                if (bubble_cnt != 16'hFFFF)
                    bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns its address as data.
module tb_fetch_stage;

    logic        clk, reset_n, IFstall, IDstall, br_resolve, br_taken;
    logic [31:0] br_target, imem_addr, imem_data, IDinstr, IDpc4;
    logic        IDvalid;
    logic [15:0] fetch_cnt, bubble_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .IFstall(IFstall), .IDstall(IDstall),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .IDinstr(IDinstr),
        .IDpc4(IDpc4), .IDvalid(IDvalid), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
    );

    assign imem_data = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        IFstall = 1'b0; IDstall = 1'b0;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        IFstall = 1'b0; IDstall = 1'b0;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_instr", IDinstr, 32'h0);
        chk("rst_pc4", IDpc4, 32'h0);
        chk("rst_valid", {31'd0, IDvalid}, 32'd0);
        chk("rst_fcnt", {16'd0, fetch_cnt}, 32'd0);
        chk("rst_bcnt", {16'd0, bubble_cnt}, 32'd0);
        tick();
        reset_n = 1'b1;

        // free run
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("run_instr", IDinstr, 32'h0040_0000 + 32'(4 * k));
            chk("run_pc4", IDpc4, 32'h0040_0004 + 32'(4 * k));
            chk("run_valid", {31'd0, IDvalid}, 32'd1);
        end
        chk("run_fcnt", {16'd0, fetch_cnt}, 32'd10);
        chk("run_addr", imem_addr, 32'h0040_0028);

        // data-hazard freeze for three cycles
        IDstall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h0040_0028);
            chk("stall_instr", IDinstr, 32'h0040_0024);
            chk("stall_pc4", IDpc4, 32'h0040_0028);
            chk("stall_valid", {31'd0, IDvalid}, 32'd1);
        end
        IDstall = 1'b0;
        tick();
        chk("resume_instr", IDinstr, 32'h0040_0028);
        chk("resume_addr", imem_addr, 32'h0040_002C);
        chk("resume_fcnt", {16'd0, fetch_cnt}, 32'd11);

        // taken branch at 0040_0010
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        chk("br_instr", IDinstr, 32'h0040_0010);
        IFstall = 1'b1;
        tick();
        chk("tk_bub1_valid", {31'd0, IDvalid}, 32'd0);
        chk("tk_bub1_addr", imem_addr, 32'h0040_0014);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0103;
        tick();
        br_resolve = 1'b0; br_taken = 1'b0; IFstall = 1'b0;
        chk("tk_redirect", imem_addr, 32'h0040_0100);
        chk("tk_bub2_valid", {31'd0, IDvalid}, 32'd0);
        chk("tk_bub2_instr", IDinstr, 32'h0);
        chk("tk_bcnt", {16'd0, bubble_cnt}, 32'd2);
        tick();
        chk("tk_target", IDinstr, 32'h0040_0100);
        chk("tk_target_pc4", IDpc4, 32'h0040_0104);
        chk("tk_valid", {31'd0, IDvalid}, 32'd1);
        chk("tk_fcnt", {16'd0, fetch_cnt}, 32'd6);

        // same branch not taken
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        IFstall = 1'b1;
        tick();
        chk("nt_bub_valid", {31'd0, IDvalid}, 32'd0);
        br_resolve = 1'b1; br_taken = 1'b0; br_target = 32'h0040_0103;
        tick();
        br_resolve = 1'b0; IFstall = 1'b0;
        chk("nt_instr", IDinstr, 32'h0040_0014);
        chk("nt_pc4", IDpc4, 32'h0040_0018);
        chk("nt_valid", {31'd0, IDvalid}, 32'd1);
        chk("nt_bcnt", {16'd0, bubble_cnt}, 32'd1);
        chk("nt_addr", imem_addr, 32'h0040_0018);

        // WAIT persists after IFstall drops; async reset mid-branch
        do_reset();
        tick(); tick();
        IFstall = 1'b1;
        tick();
        IFstall = 1'b0;
        tick();
        chk("wait_valid", {31'd0, IDvalid}, 32'd0);
        chk("wait_addr", imem_addr, 32'h0040_0008);
        chk("wait_bcnt", {16'd0, bubble_cnt}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_addr", imem_addr, 32'h0040_0000);
        chk("arst_valid", {31'd0, IDvalid}, 32'd0);
        chk("arst_fcnt", {16'd0, fetch_cnt}, 32'd0);
        chk("arst_bcnt", {16'd0, bubble_cnt}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_resume", IDinstr, 32'h0040_0000);
        chk("arst_resume_valid", {31'd0, IDvalid}, 32'd1);

        // PC wrap; also exercises target bit masking
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        tick();
        br_resolve = 1'b0; br_taken = 1'b0;
        chk("wrap_pc", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", IDpc4, 32'h0000_0000);
        chk("wrap_instr", IDinstr, 32'hFFFF_FFFC);

        // resolve with IDstall: IF/ID holds, PC still redirects
        IDstall = 1'b1; br_resolve = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0200;
        tick();
        IDstall = 1'b0; br_resolve = 1'b0; br_taken = 1'b0;
        chk("rs_hold_instr", IDinstr, 32'hFFFF_FFFC);
        chk("rs_hold_valid", {31'd0, IDvalid}, 32'd1);
        chk("rs_addr", imem_addr, 32'h0040_0200);
        tick();
        chk("rs_instr", IDinstr, 32'h0040_0200);

        // bubble counter saturation
        do_reset();
        IFstall = 1'b1;
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        chk("sat_below", {16'd0, bubble_cnt}, 32'h0000_FFFE);
        tick();
        chk("sat_reach", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        for (int k = 0; k < 5; k++) tick();
        chk("sat_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        chk("sat_fcnt", {16'd0, fetch_cnt}, 32'd0);
        IFstall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It owns the program counter, drives the instruction-memory address, and registers the fetched word plus PC+4 into ID. It consumes the hazard unit's `IFstall` and `IDstall` outputs and the branch resolution from EX. It freezes, bubbles or redirects the front end accordingly.

## Interface
Parameters:
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset (word aligned).
- `NOP`, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IFstall`  in  1  a branch is in ID or EX; stop fetching down the fall-through path.
- `IDstall`  in  1  data hazard; freeze PC and IF/ID.
- `br_resolve`  in  1  EX resolves a branch this cycle.
- `br_taken`  in  1  resolved branch is taken; valid only with `br_resolve`.
- `br_target`  in  32  taken-branch address; bits [1:0] are ignored and forced to 0.
- `imem_addr`  out  32  instruction-memory address, equal to the PC register.
- `imem_data`  in  32  instruction word; combinational from `imem_addr` within the same cycle.
- `IDinstr`  out  32  IF/ID instruction.
- `IDpc4`  out  32  IF/ID PC+4 of that instruction.
- `IDvalid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `fetch_cnt`  out  16  valid instructions issued into IF/ID; wraps.
- `bubble_cnt`  out  16  bubbles inserted; saturates at 16'hFFFF.

## Operation
- States:
  - RUN: normal fetch.
  - WAIT: a branch is pending and PC is held at the fall-through address.
- Per-cycle action, in priority order:
  1. `reset_n`=0: PC=`RESET_PC`, `IDinstr`=`NOP`, `IDpc4`=0, `IDvalid`=0, both counters 0, state RUN. Applies asynchronously, including mid-branch.
  2. `br_resolve`=1, any state, taken:
     - PC <= {br_target[31:2],2'b00}.
     - IF/ID <= bubble.
     - state <= RUN.
  3. `br_resolve`=1, any state, not taken:
     - IF/ID <= {imem_data, PC+4, 1}.
     - PC <= PC+4.
     - state <= RUN.
     - `IFstall` is ignored this cycle.
  4. With `br_resolve`=1, if `IDstall`=1 as well, IF/ID holds instead of loading. The PC update above still occurs.
  5. `IDstall`=1 (no resolve): PC, IF/ID and state all hold. Counters unchanged.
  6. `IFstall`=1 (no resolve, no IDstall):
     - PC holds.
     - IF/ID <= bubble (`NOP`, `IDpc4`=0, `IDvalid`=0).
     - state <= WAIT.
  7. In WAIT with none of the above: IF/ID <= bubble, PC holds. A resolve is still outstanding even if `IFstall` has dropped.
  8. Otherwise (RUN): IF/ID <= {imem_data, PC+4, 1}; PC <= PC+4.
- `fetch_cnt` increments on every edge that loads `IDvalid`=1.
- `bubble_cnt` increments on every edge that loads `IDvalid`=0 by cases 2, 6 or 7. Holds at FFFF.
- Arithmetic: PC+4 is modulo 2^32 (FFFF_FFFC+4 = 0000_0000). No delay slot: the fall-through is branch PC+4.
- `br_resolve` in RUN without a prior IFstall is legal and handled identically.

## Timing
- All outputs are registered except `imem_addr`, which is the PC flop output.
- Fetch latency: the word at `imem_addr` in cycle N appears on `IDinstr` in cycle N+1.
- Redirect: `br_resolve`&`br_taken` in cycle N gives `imem_addr`=target in N+1 and the target on `IDinstr` in N+2.
- Not-taken: the fall-through instruction is on `IDinstr` in N+1.
- Branch penalty: a branch entering ID in cycle B resolves in EX at B+1.
  - Taken: 2 bubbles.
  - Not taken: 1 bubble.
- `IDstall` freezes everything for exactly the cycles it is asserted. The first edge after deassertion resumes from the held state.

## Test plan
- Reset then free run, imem returns address as data, no stalls:
  - `IDinstr` = 0040_0000, 0040_0004, … on successive cycles.
  - `IDpc4` = instr+4.
  - After 10 cycles, `fetch_cnt`=10.
- `IDstall` high for 3 cycles mid-stream:
  - `imem_addr`, `IDinstr`, `IDpc4` and `IDvalid` are unchanged for those 3 cycles.
  - The sequence then continues with no skipped or duplicated address.
- Branch at 0040_0010, `IFstall` for 2 cycles, then `br_resolve`=1, `br_taken`=1, `br_target`=0040_0103:
  - `imem_addr`=0040_0100 next cycle.
  - 2 bubbles with `IDvalid`=0.
  - `bubble_cnt`=2.
  - Target word on `IDinstr` 2 cycles after resolve.
- Same branch not taken: 1 bubble, then `IDinstr`=word at 0040_0014, `IDpc4`=0040_0018.
- `reset_n` pulsed low while in WAIT:
  - Immediately PC=0040_0000, `IDvalid`=0, counters 0.
  - After release, normal fetch resumes from `RESET_PC`.
- PC=FFFF_FFFC, no stall: next `imem_addr`=0000_0000 and `IDpc4`=0000_0000.
- Saturation: force 65540 bubbles; `bubble_cnt` stays at FFFF.
